// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the bit-serial ALU sequencer: opcodes, FSM encoding,
// opcode-to-slice select decode and the reversible-gate primitives used by the slice.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_NOTA  = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Select bit positions and function field values for the 1-bit slice.
  localparam int SEL_INVB = 0;
  localparam int SEL_CEN  = 1;

  localparam logic [1:0] FN_SUM  = 2'b00;
  localparam logic [1:0] FN_AND  = 2'b01;
  localparam logic [1:0] FN_OR   = 2'b10;
  localparam logic [1:0] FN_PASS = 2'b11;

  // In the pass function B is unused, so the invert bit is reused to invert A.
  localparam logic [3:0] SEL_ADD   = {FN_SUM,  2'b10};
  localparam logic [3:0] SEL_SUB   = {FN_SUM,  2'b11};
  localparam logic [3:0] SEL_AND   = {FN_AND,  2'b00};
  localparam logic [3:0] SEL_OR    = {FN_OR,   2'b00};
  localparam logic [3:0] SEL_XOR   = {FN_SUM,  2'b00};
  localparam logic [3:0] SEL_XNOR  = {FN_SUM,  2'b01};
  localparam logic [3:0] SEL_NOTA  = {FN_PASS, 2'b01};
  localparam logic [3:0] SEL_PASSA = {FN_PASS, 2'b00};

  localparam logic [31:0] SEL_TABLE = {SEL_PASSA, SEL_NOTA, SEL_XNOR, SEL_XOR,
                                       SEL_OR,    SEL_AND,  SEL_SUB,  SEL_ADD};

  function automatic logic [3:0] decode_sel(input logic [2:0] op);
    return SEL_TABLE[{op, 2'b00} +: 4];
  endfunction

  // Feynman (controlled-NOT) cell: target output only.
  function automatic logic cnot(input logic ctrl, input logic tgt);
    return tgt ^ ctrl;
  endfunction

  // Toffoli (controlled-controlled-NOT) cell: target output only.
  function automatic logic toffoli(input logic c1, input logic c2, input logic tgt);
    return tgt ^ (c1 & c2);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit function-generator slice built from CNOT/Toffoli cells.
// s[0] inverts B (or A in pass mode), s[1] enables the carry chain, s[3:2] picks the function.
module alu_bit_slice
  import alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] s,
  output logic       r,
  output logic       cout
);

  logic bx;
  logic cin_g;
  logic p;
  logic g;
  logic sum;
  logic c_raw;

  assign bx    = cnot(s[SEL_INVB], b);
  assign cin_g = toffoli(s[SEL_CEN], cin, 1'b0);
  assign p     = cnot(a, bx);
  assign g     = toffoli(a, bx, 1'b0);
  assign sum   = cnot(p, cin_g);
  // Generate and propagate-with-carry are mutually exclusive, so XOR acts as OR here.
  assign c_raw = toffoli(p, cin_g, g);
  assign cout  = toffoli(s[SEL_CEN], c_raw, 1'b0);

  // NOTE: assign a default before the case so every path drives r and no latch is inferred.
  always_comb begin
    r = sum;
    case (s[3:2])
      FN_SUM:  r = sum;
      FN_AND:  r = g;
      FN_OR:   r = cnot(p, g);
      FN_PASS: r = cnot(a, s[SEL_INVB]);
      default: r = sum;
    endcase
  end

endmodule

// File: rtl/bitserial_alu_ctrl.sv
// Sequencer that runs one alu_bit_slice LSB-first over WIDTH bits, one bit per clock,
// with the ripple carry held in a register between bits.
module bitserial_alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [2:0]       op_l;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [3:0]       sel;
  logic             r_bit;
  logic             cout_bit;

  assign sel        = decode_sel(op_l);
  assign shreg_next = {r_bit, shreg[WIDTH-1:1]};

  alu_bit_slice u_slice (
    .a    (a_l[cnt]),
    .b    (b_l[cnt]),
    .cin  (carry_q),
    .s    (sel),
    .r    (r_bit),
    .cout (cout_bit)
  );

  // NOTE: reset is synchronous and sampled inside the clocked block; all state uses
  // non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      carry_q   <= 1'b0;
      a_l       <= '0;
      b_l       <= '0;
      op_l      <= OP_ADD;
      shreg     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_l     <= a;
            b_l     <= b;
            op_l    <= op;
            carry_q <= (op == OP_SUB);
            cnt     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          shreg   <= shreg_next;
          carry_q <= cout_bit;
          cnt     <= cnt + 1'b1;
          // Outputs are only published here so they never glitch mid-operation.
          if (cnt == LAST_BIT) begin
            result    <= shreg_next;
            carry_out <= cout_bit;
            zero      <= (shreg_next == '0);
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// Directed self-checking bench for bitserial_alu_ctrl at WIDTH=8.
module tb_bitserial_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  int n_checks = 0;
  int n_pass   = 0;

  bitserial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, watch the whole window and check timing and outputs.
  // With disturb set, start is pulsed and operands are zeroed while busy.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH-1:0] exp_r, input logic exp_c,
                        input logic exp_z, input bit disturb);
    int busy_n;
    int done_n;
    int done_at;
    logic [WIDTH-1:0] prev_r;
    prev_r  = result;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    for (int n = 0; n <= WIDTH + 2; n++) begin
      if (n > 0) tick();
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = n;
      end
      if (n == WIDTH / 2) check({tag, " held_mid_run"}, result, prev_r);
      if (disturb && n < WIDTH + 1) begin
        start = 1'b1; a = '0; b = '0; op = OP_AND;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, " done_latency"}, done_at, WIDTH);
    check({tag, " done_count"}, done_n, 1);
    check({tag, " busy_cycles"}, busy_n, WIDTH + 1);
    check({tag, " idle_after"}, busy, 1'b0);
    check({tag, " result"}, result, exp_r);
    check({tag, " carry_out"}, carry_out, exp_c);
    check({tag, " zero"}, zero, exp_z);
  endtask

  initial begin
    int last_done;
    int gaps;
    logic prev_done;

    rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
    tick();
    tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 8'h00);
    check("reset carry", carry_out, 1'b0);
    check("reset zero", zero, 1'b0);
    rst = 1'b0;
    tick();

    run_op("add_ff_01",  OP_ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub_05_07",  OP_SUB,   8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_07_05",  OP_SUB,   8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0);
    run_op("sub_equal",  OP_SUB,   8'h5A, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("and",        OP_AND,   8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 1'b0);
    run_op("or",         OP_OR,    8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0, 1'b0);
    run_op("xor",        OP_XOR,   8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0);
    run_op("xnor",       OP_XNOR,  8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0, 1'b0);
    run_op("nota",       OP_NOTA,  8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
    run_op("passa",      OP_PASSA, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0);
    run_op("add_carries", OP_ADD,  8'h9C, 8'h77, 8'h13, 1'b1, 1'b0, 1'b0);
    run_op("disturbed",  OP_ADD,   8'h0F, 8'hF1, 8'h00, 1'b1, 1'b1, 1'b1);
    run_op("add_0f_f0",  OP_ADD,   8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);

    // Abort an ADD four cycles in; outputs must clear and no done may follow.
    start = 1'b1; op = OP_ADD; a = 8'h80; b = 8'h80;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort result", result, 8'h00);
    check("abort carry", carry_out, 1'b0);
    check("abort zero", zero, 1'b0);
    rst = 1'b0;
    begin
      int stray = 0;
      for (int n = 0; n < WIDTH + 4; n++) begin
        tick();
        if (done || busy) stray++;
      end
      check("abort no_done", stray, 0);
    end
    run_op("add_12_34",  OP_ADD,   8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

    // Start held high: accepted every WIDTH+2 cycles, done never back-to-back.
    start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
    last_done = -1;
    gaps = 0;
    prev_done = 1'b0;
    for (int n = 0; n < 5 * (WIDTH + 2); n++) begin
      tick();
      if (done) begin
        if (prev_done) check("b2b consecutive_done", 1, 0);
        if (last_done >= 0) begin
          check("b2b spacing", n - last_done, WIDTH + 2);
          gaps++;
        end
        last_done = n;
      end
      prev_done = done;
    end
    check("b2b gap_count", gaps >= 3, 1'b1);
    start = 1'b0;
    begin
      int wait_n = 0;
      while (busy && wait_n < 3 * WIDTH) begin
        tick();
        wait_n++;
      end
      check("b2b drains", busy, 1'b0);
    end
    check("b2b result", result, 8'h02);
    check("b2b carry", carry_out, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
